// File: rtl/jpeg_pkg.sv
// Shared JPEG constants: block size, quality-50 luminance quant table, its
// 16-bit fixed-point reciprocals and the zigzag-to-natural index map.
package jpeg_pkg;

   localparam int unsigned BLOCK_SIZE = 64;

   // Natural (row-major) order.
   localparam int unsigned Q_TABLE [BLOCK_SIZE] = '{
      16,  11,  10,  16,  24,  40,  51,  61,
      12,  12,  14,  19,  26,  58,  60,  55,
      14,  13,  16,  24,  40,  57,  69,  56,
      14,  17,  22,  29,  51,  87,  80,  62,
      18,  22,  37,  56,  68, 109, 103,  77,
      24,  35,  55,  64,  81, 104, 113,  92,
      49,  64,  78,  87, 103, 121, 120, 101,
      72,  92,  95,  98, 112, 100, 103,  99
   };

   // ceil(65536 / Q_TABLE[k]), natural order.
   localparam int unsigned R_TABLE [BLOCK_SIZE] = '{
      4096, 5958, 6554, 4096, 2731, 1639, 1286, 1075,
      5462, 5462, 4682, 3450, 2521, 1130, 1093, 1192,
      4682, 5042, 4096, 2731, 1639, 1150,  950, 1171,
      4682, 3856, 2979, 2260, 1286,  754,  820, 1058,
      3641, 2979, 1772, 1171,  964,  602,  637,  852,
      2731, 1873, 1192, 1024,  810,  631,  580,  713,
      1338, 1024,  841,  754,  637,  542,  547,  649,
       911,  713,  690,  669,  586,  656,  637,  662
   };

   // Zigzag position -> natural index.
   localparam int unsigned ZZ_TABLE [BLOCK_SIZE] = '{
       0,  1,  8, 16,  9,  2,  3, 10,
      17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34,
      27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36,
      29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46,
      53, 60, 61, 54, 47, 55, 62, 63
   };

endpackage

// File: rtl/quant_mult.sv
// Two-stage sign-magnitude quantizer: |x| * R[k] >> 16, saturated, sign restored.
// Define QUANT_ROUND_EN to round half away from zero instead of truncating.
module quant_mult
   import jpeg_pkg::*;
#(
   parameter int unsigned COEF_W = 12,
   parameter int unsigned OUT_W  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_first,
   input  logic [COEF_W-1:0] in_data,
   input  logic [5:0]        in_k,
   output logic [OUT_W-1:0]  data_out,
   output logic              out_valid,
   output logic              blk_start
);

   localparam logic [29:0] POS_LIM = 30'((1 << (OUT_W - 1)) - 1);
   localparam logic [29:0] NEG_LIM = POS_LIM + 30'd1;

   logic [COEF_W:0]  mag;
   logic [29:0]      prod;
   logic [29:0]      prod_q;
   logic             neg_q;
   logic             v1_q;
   logic             f1_q;
   logic [29:0]      mag_sh;
   logic [29:0]      limit;
   logic [OUT_W-1:0] sat_mag;
   logic [OUT_W-1:0] res;

   // Extra magnitude bit so the most negative input maps to a positive value.
   assign mag = in_data[COEF_W-1] ? -{in_data[COEF_W-1], in_data} : {1'b0, in_data};

   always_comb begin
      prod = 30'(mag) * 30'(R_TABLE[in_k]);
`ifdef QUANT_ROUND_EN
      prod = prod + 30'd32768;
`endif
   end

   always_comb begin
      mag_sh  = prod_q >> 16;
      limit   = neg_q ? NEG_LIM : POS_LIM;
      sat_mag = (mag_sh > limit) ? limit[OUT_W-1:0] : mag_sh[OUT_W-1:0];
      res     = neg_q ? -sat_mag : sat_mag;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prod_q    <= '0;
         neg_q     <= 1'b0;
         v1_q      <= 1'b0;
         f1_q      <= 1'b0;
         data_out  <= '0;
         out_valid <= 1'b0;
         blk_start <= 1'b0;
      end else begin
         prod_q    <= prod;
         neg_q     <= in_data[COEF_W-1];
         v1_q      <= in_valid;
         f1_q      <= in_first;
         data_out  <= v1_q ? res : '0;
         out_valid <= v1_q;
         blk_start <= v1_q & f1_q;
      end
   end

endmodule

// File: rtl/quant_zigzag.sv
// 8x8 ping-pong buffer with zigzag readout feeding the quantizer pipeline.
// QUANT_ROUND_EN (see quant_mult) selects rounding; latency is unchanged.
module quant_zigzag
   import jpeg_pkg::*;
#(
   parameter int unsigned COEF_W = 12,
   parameter int unsigned OUT_W  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enb,
   input  logic [COEF_W-1:0] data_in,
   output logic [OUT_W-1:0]  data_out,
   output logic              out_valid,
   output logic              blk_start
);

   logic [COEF_W-1:0] mem [2][BLOCK_SIZE];

   logic [5:0]        wr_cnt_q;
   logic [5:0]        rd_cnt_q;
   logic              wr_bank_q;
   logic              rd_bank_q;
   logic              rd_active_q;
   logic              rd_valid_q;
   logic              rd_first_q;
   logic [COEF_W-1:0] rd_data_q;
   logic [5:0]        rd_k_q;
   logic              blk_done;
   logic [5:0]        rd_addr;

   assign blk_done = enb && (wr_cnt_q == 6'(BLOCK_SIZE - 1));
   assign rd_addr  = 6'(ZZ_TABLE[rd_cnt_q]);

   // Buffer RAM is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (enb) begin
         mem[wr_bank_q][wr_cnt_q] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         rd_active_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_first_q  <= 1'b0;
         rd_data_q   <= '0;
         rd_k_q      <= '0;
      end else begin
         if (enb) begin
            wr_cnt_q <= wr_cnt_q + 6'd1;
         end
         rd_valid_q <= rd_active_q;
         rd_first_q <= rd_active_q && (rd_cnt_q == 6'd0);
         if (rd_active_q) begin
            rd_data_q <= mem[rd_bank_q][rd_addr];
            rd_k_q    <= rd_addr;
         end
         // A block can only complete as the previous readout consumes its last entry.
         if (blk_done) begin
            wr_bank_q   <= ~wr_bank_q;
            rd_bank_q   <= wr_bank_q;
            rd_active_q <= 1'b1;
            rd_cnt_q    <= '0;
         end else if (rd_active_q) begin
            rd_cnt_q <= rd_cnt_q + 6'd1;
            if (rd_cnt_q == 6'(BLOCK_SIZE - 1)) begin
               rd_active_q <= 1'b0;
            end
         end
      end
   end

   quant_mult #(
      .COEF_W (COEF_W),
      .OUT_W  (OUT_W)
   ) u_quant_mult (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_valid_q),
      .in_first  (rd_first_q),
      .in_data   (rd_data_q),
      .in_k      (rd_k_q),
      .data_out  (data_out),
      .out_valid (out_valid),
      .blk_start (blk_start)
   );

endmodule

// File: tb/tb_quant_zigzag.sv
// Scoreboard bench for quant_zigzag: expected outputs, flags and cycles are queued
// when a block completes and compared as the DUT emits them.
module tb_quant_zigzag;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enb = 1'b0;
   logic [11:0] data_in = '0;
   logic [11:0] data_out;
   logic        out_valid;
   logic        blk_start;

   quant_zigzag #(
      .COEF_W (12),
      .OUT_W  (12)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enb       (enb),
      .data_in   (data_in),
      .data_out  (data_out),
      .out_valid (out_valid),
      .blk_start (blk_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      int val;
      int first;
      int cyc;
   } exp_t;

   int q_tab [64] = '{
      16,  11,  10,  16,  24,  40,  51,  61,
      12,  12,  14,  19,  26,  58,  60,  55,
      14,  13,  16,  24,  40,  57,  69,  56,
      14,  17,  22,  29,  51,  87,  80,  62,
      18,  22,  37,  56,  68, 109, 103,  77,
      24,  35,  55,  64,  81, 104, 113,  92,
      49,  64,  78,  87, 103, 121, 120, 101,
      72,  92,  95,  98, 112, 100, 103,  99
   };

   int   zz [64];
   int   blk [64];
   exp_t sb [$];
   int   out_log [$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   valid_cnt = 0;
   int   start_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int model_q(input int x, input int k);
      int     mag;
      int     r;
      longint p;
      int     q;
      mag = (x < 0) ? -x : x;
      r   = (65536 + q_tab[k] - 1) / q_tab[k];
      p   = longint'(mag) * longint'(r);
`ifdef QUANT_ROUND_EN
      p   = p + 32768;
`endif
      q   = int'(p >>> 16);
      if (x < 0) begin
         if (q > 2048) q = 2048;
         return -q;
      end
      if (q > 2047) q = 2047;
      return q;
   endfunction

   // Zigzag walk over anti-diagonals, independent of the RTL table.
   task automatic build_zz();
      int n = 0;
      for (int s = 0; s < 15; s++) begin
         if (s % 2 == 0) begin
            for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
               zz[n] = r * 8 + (s - r);
               n++;
            end
         end else begin
            for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
               zz[n] = r * 8 + (s - r);
               n++;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst && out_valid) begin
         exp_t e;
         valid_cnt++;
         if (blk_start) start_cnt++;
         out_log.push_back(int'($signed(data_out)));
         if (sb.size() == 0) begin
            check_eq("unexpected_output", 1, 0);
         end else begin
            e = sb.pop_front();
            check_eq("data", int'($signed(data_out)), e.val);
            check_eq("blk_start", int'(blk_start), e.first);
            check_eq("out_cycle", cyc, e.cyc);
         end
      end else if (blk_start) begin
         check_eq("blk_start_idle", 1, 0);
      end
   end

   task automatic send_block(input bit gaps);
      int acc;
      for (int i = 0; i < 64; i++) begin
         if (gaps) begin
            @(posedge clk); #1;
            enb = 1'b0;
         end
         @(posedge clk); #1;
         enb     = 1'b1;
         data_in = 12'(blk[i]);
      end
      acc = cyc + 1;
      for (int j = 0; j < 64; j++) begin
         sb.push_back('{val: model_q(blk[zz[j]], zz[j]), first: (j == 0) ? 1 : 0,
                        cyc: acc + 3 + j});
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      enb     = 1'b0;
      data_in = '0;
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
      check_eq("drain_left", sb.size(), 0);
   endtask

   task automatic clear_logs();
      out_log.delete();
      valid_cnt = 0;
      start_cnt = 0;
   endtask

   task automatic fill_q_block();
      for (int k = 0; k < 64; k++) blk[k] = q_tab[k];
      blk[1] = 33;
      blk[8] = 24;
   endtask

   task automatic pulse_reset(input string tag);
      rst = 1'b0;
      #1;
      check_eq({tag, "_data_out"}, int'(data_out), 0);
      check_eq({tag, "_out_valid"}, int'(out_valid), 0);
      check_eq({tag, "_blk_start"}, int'(blk_start), 0);
      sb.delete();
      enb = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      build_zz();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_data_out", int'(data_out), 0);
      check_eq("rst_out_valid", int'(out_valid), 0);
      check_eq("rst_blk_start", int'(blk_start), 0);
      rst = 1'b1;
      idle();

      // Q-valued block with two boosted entries.
      clear_logs();
      fill_q_block();
      send_block(1'b0);
      idle();
      drain();
      check_eq("q_blk_zz0", out_log[0], 1);
      check_eq("q_blk_zz1", out_log[1], 3);
      check_eq("q_blk_zz2", out_log[2], 2);
      check_eq("q_blk_zz3", out_log[3], 1);
      check_eq("q_blk_starts", start_cnt, 1);

      // Small negative DC: rounding decides -1 vs -2.
      clear_logs();
      for (int k = 0; k < 64; k++) blk[k] = 0;
      blk[0] = -24;
      send_block(1'b0);
      idle();
      drain();
`ifdef QUANT_ROUND_EN
      check_eq("neg_dc", out_log[0], -2);
`else
      check_eq("neg_dc", out_log[0], -1);
`endif
      check_eq("neg_dc_ac", out_log[63], 0);

      // Large DC values, including the most negative input.
      clear_logs();
      blk[0] = 800;
      send_block(1'b0);
      blk[0] = -2048;
      send_block(1'b0);
      idle();
      drain();
      check_eq("dc_800", out_log[0], 50);
      check_eq("dc_m2048", out_log[64], -128);

      // Three random blocks back to back.
      clear_logs();
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(4095)) - 2048;
         send_block(1'b0);
      end
      idle();
      drain();
      check_eq("b2b_valid_cycles", valid_cnt, 192);
      check_eq("b2b_starts", start_cnt, 3);

      // Every-other-cycle enb.
      clear_logs();
      fill_q_block();
      send_block(1'b1);
      idle();
      drain();
      check_eq("gap_zz1", out_log[1], 3);
      check_eq("gap_valid_cycles", valid_cnt, 64);

      // Reset after a partial block.
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         enb     = 1'b1;
         data_in = 12'(i + 100);
      end
      pulse_reset("rst_partial");

      // Reset during readout.
      for (int k = 0; k < 64; k++) blk[k] = 500 - k * 13;
      send_block(1'b0);
      idle();
      repeat (20) @(posedge clk);
      #1;
      check_eq("busy_before_rst", int'(out_valid), 1);
      pulse_reset("rst_readout");

      // Clean block after both resets.
      clear_logs();
      for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(4095)) - 2048;
      send_block(1'b0);
      idle();
      drain();
      check_eq("post_rst_valid_cycles", valid_cnt, 64);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/quant_zigzag.md
QUANT_ZIGZAG -- requirements
Module: quant_zigzag

Interface
REQ-001 SHALL have parameter COEF_W, default 12, meaning the width of the signed DCT coefficient input.
REQ-002 SHALL have parameter OUT_W, default 12, meaning the width of the signed quantized output.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port enb, input, 1 bit: data_in is valid this cycle; one coefficient is accepted per cycle while high.
REQ-006 SHALL have port data_in, input, COEF_W bits: signed DCT coefficient, 8x8 block, row-major natural order.
REQ-007 SHALL have port data_out, output, OUT_W bits: signed quantized coefficient, in zigzag order.
REQ-008 SHALL have port out_valid, output, 1 bit: data_out is valid this cycle.
REQ-009 SHALL have port blk_start, output, 1 bit: high with out_valid on the DC (zigzag index 0) output of each block.

Function
REQ-010 SHALL write accepted coefficients into the current write bank of a 2x64-entry ping-pong buffer, at address 0..63 from a 6-bit write counter.
REQ-011 SHALL, in the cycle the 64th coefficient is accepted, wrap the write counter to 0, swap banks, and start readout of the completed bank.
REQ-012 SHALL read the completed bank in JPEG zigzag order, one entry per cycle, for 64 consecutive cycles with no stalls.
REQ-013 SHALL assert out_valid for exactly 64 consecutive cycles per block; the first output appears 3 cycles after the accepting edge of the 64th input.
REQ-014 SHALL treat gaps in enb as write stalls only; readout is never paused by enb.
REQ-015 SHALL sustain back-to-back blocks with enb held high, giving gapless output; no overflow is possible because readout (64 cycles) never exceeds fill time.
REQ-016 SHALL quantize as q = sign(x) * ((|x| * R[k]) >> 16), where k is the natural index and R[k] = ceil(65536 / Q[k]); Q is the standard JPEG luminance table (quality 50).
REQ-017 SHALL compute |x| on COEF_W+1 bits so that -2048 is handled, use a 30-bit product, and saturate the result to the OUT_W signed range.
REQ-018 SHALL yield a negative zero as 0 (sign-magnitude quantization, symmetric about zero).
REQ-019 SHALL complete a readout already in progress unaffected if a new block finishes filling during that readout.

Reset
REQ-020 SHALL, on rst low, immediately clear data_out=0, out_valid=0, blk_start=0, the write counter, the read counter, the bank select and the readout-active flag.
REQ-021 SHALL discard any partial block or in-progress readout when reset is asserted mid-operation; buffer RAM contents are not reset.
REQ-022 SHALL treat the first accepted coefficient after reset release as natural index 0 of a new block.

Configuration
REQ-023 SHALL, with QUANT_ROUND_EN defined, add 32768 to |x|*R[k] before the shift (round half away from zero).
REQ-024 SHALL, with QUANT_ROUND_EN undefined, omit that addition (truncate toward zero); latency and handshake are identical in both builds.

Structure
REQ-025 SHALL take from shared package jpeg_pkg: BLOCK_SIZE=64, the Q table, the R reciprocal table, and the zigzag-to-natural index table.
REQ-026 SHALL place the magnitude/multiply/round/saturate/sign-restore pipeline in sub-module quant_mult (2 register stages); buffer, counters and control stay in quant_zigzag.

Verification
REQ-027 SHALL be covered by: reset, then 64 inputs with x[k]=Q[k] except x[1]=33 and x[8]=24 -> outputs zigzag 1,3,2 then 61 ones; blk_start on the first only; first valid at 3 cycles after the 64th input.
REQ-028 SHALL be covered by: DC x[0]=-24, all others 0 -> first output -2 with QUANT_ROUND_EN, -1 without; the remaining 63 outputs are 0.
REQ-029 SHALL be covered by: x[0]=800 and x[0]=-2048 in successive blocks -> first outputs 50 and -128.
REQ-030 SHALL be covered by: three blocks, enb held high -> 192 gapless out_valid cycles, with blk_start at output cycles 0, 64, 128.
REQ-031 SHALL be covered by: enb toggled every other cycle for one block -> output starts 3 cycles after the 64th accepted sample, values as in REQ-027.
REQ-032 SHALL be covered by: rst low after 30 inputs and again mid-readout -> all outputs 0 next; the following full block outputs correctly with no stale data.
